video_frame_monitor: RTL
========================

// Module: video_frame_monitor
// PURPOSE
//  Synthesizable raster monitor that sits on the core's video outputs (rgb/hsync/vsync/blank), beside the VGA scan-out.
//  Measures line/frame timing, signs every frame with a CRC-16 over active pixels, and flags timing instability.
//  Gives sim benches and on-FPGA debug a per-frame golden signature, with no dependence on a host VGA capture hook.
// PARAMETERS
//  RGB_W     9   pixel width hashed per active pixel (1..16)
//  HCNT_W    10  width of pixel-per-line counters
//  VCNT_W    10  width of line-per-frame counters
//  SYNC_POL  0   sync assertion level: 0 = active-low syncs, 1 = active-high
// PORTS
//  clk_12mhz     in   1        system clock
//  reset_n       in   1        asynchronous, active-low reset
//  pix_ce_i      in   1        pixel-clock enable; all video sampling occurs only when high
//  rgb_i         in   RGB_W    pixel colour
//  hsync_i       in   1        horizontal sync
//  vsync_i       in   1        vertical sync
//  hblank_i      in   1        horizontal blank (1 = blanked)
//  vblank_i      in   1        vertical blank (1 = blanked)
//  h_total_o     out  HCNT_W   pixels per line, from the last line of the last complete frame
//  h_active_o    out  HCNT_W   active pixels, from the last active line of the last complete frame
//  v_active_o    out  VCNT_W   lines containing >=1 active pixel in the last complete frame
//  frame_crc_o   out  16       CRC of the last complete frame
//  frame_cnt_o   out  16       complete frames seen; wraps 0xFFFF->0
//  frame_done_o  out  1        one-clk pulse when the outputs above update
//  stable_o      out  1        last two complete frames had identical h_total/h_active/v_active
//  timing_err_o  out  1        sticky; set on any timing mismatch while stable_o=1
// BEHAVIOUR
//  - Reset: all outputs 0; FSM = S_WAIT; CRC accumulator = 16'hFFFF; all counters 0.
//  - Sync edge: assertion edge of hsync/vsync (level per SYNC_POL), detected from a registered previous value.
//    The previous value updates only on pix_ce_i; when pix_ce_i=0 nothing updates.
//  - FSM S_WAIT: ignore video until the first vsync edge, then go to S_FRAME. This first, partial frame is never reported.
//  - FSM S_FRAME, per pix_ce_i:
//    - Pixel count increments, saturating at all-ones.
//    - If !hblank_i && !vblank_i: active count +1 (saturating); CRC absorbs rgb_i MSB-first; line_has_active set.
//    - hsync edge: h_total <= pixel count; if line_has_active, h_act_last <= active count and line count +1 (saturating).
//      Then pixel count, active count and line_has_active clear. The edge pixel counts as pixel 0 of the new line.
//  - vsync edge in S_FRAME: close the frame as one atomic update.
//    - Publish h_total_o, h_active_o, v_active_o, frame_crc_o; frame_cnt_o +1.
//    - Drive frame_done_o high for exactly one clk_12mhz cycle, on the cycle after the edge sample.
//    - Reinit CRC to FFFF; clear line count. The edge pixel itself is hashed into the new frame if active.
//  - Simultaneous hsync and vsync edges: line close first, then frame close; the closing line is included in the frame.
//  - stable_o at frame close: 1 iff the new timing triple equals the previous published triple (needs >=2 complete frames).
//    timing_err_o is set if stable_o was 1 and the triples differ. It clears only on reset.
//  - CRC: CRC-16-CCITT, poly 0x1021, init 0xFFFF, no reflect, no final XOR; RGB_W bits absorbed per active pixel in one cycle.
//  - reset_n low mid-frame: immediate return to the reset state. The next report comes after two further vsync edges.
// CONFIGURATION
//  - CRC_COMPARE_EN defined: adds ports expected_crc_i (in, 16) and crc_mismatch_o (out, 1).
//    crc_mismatch_o is sticky, set on the frame_done_o cycle when frame_crc_o != expected_crc_i, cleared by reset.
//    Reset value 0.
//  - CRC_COMPARE_EN undefined: neither port exists; no compare logic.
// STRUCTURE
//  - video_mon_pkg (shared, included by the monitor and the benches): CRC_POLY=16'h1021, CRC_INIT=16'hFFFF,
//    FSM state encodings S_WAIT/S_FRAME, function crc16_next(crc, data, nbits).
//  - Sub-module crc16_step #(W): combinational parallel CRC update; the monitor holds the CRC register.
//  - Top: sync-edge detect, counters, FSM, publish/stability registers.
// TESTING
//  1. Reset check: hold reset_n=0 with active video toggling -> all outputs 0, no frame_done_o.
//  2. Synthetic raster, pix_ce every cycle, RGB_W=9:
//     20 px/line, 16 active; 10 lines/frame, 8 active; rgb=9'h1FF constant.
//     -> after the 2nd vsync: h_total=20, h_active=16, v_active=8, frame_cnt=1, CRC matches the bench model.
//     -> after the 3rd vsync: stable_o=1.
//  3. Change the raster to 18 active px while stable -> timing_err_o=1 at the next frame_done, held thereafter.
//     stable_o=0 for that frame and returns to 1 one frame later.
//  4. pix_ce_i toggling 1-of-2 with the same raster -> identical counts and CRC to scenario 2.
//  5. hsync and vsync edges on the same sample -> last line counted (v_active=8).
//     Then reset_n pulsed mid-frame -> outputs 0, next frame_done only after 2 vsyncs.
//  6. CRC_COMPARE_EN defined:
//     expected_crc_i=model CRC -> crc_mismatch_o stays 0.
//     Flip one rgb bit in one pixel -> crc_mismatch_o=1 at that frame_done, sticky.

Source files
------------

// File: rtl/video_mon_pkg.sv
// Shared constants and CRC-16-CCITT helper for the video frame monitor.
package video_mon_pkg;
  localparam logic [15:0] CRC_POLY = 16'h1021;
  localparam logic [15:0] CRC_INIT = 16'hFFFF;

  localparam logic [0:0] S_WAIT  = 1'b0;
  localparam logic [0:0] S_FRAME = 1'b1;

  // Absorbs data[nbits-1:0] MSB-first into crc; no reflection, no final XOR.
  function automatic logic [15:0] crc16_next(input logic [15:0] crc,
                                             input logic [15:0] data,
                                             input int          nbits);
    logic [15:0] c;
    c = crc;
    for (int i = 15; i >= 0; i--)
      if (i < nbits) c = {c[14:0], 1'b0} ^ ((c[15] ^ data[i]) ? CRC_POLY : 16'h0000);
    return c;
  endfunction
endpackage

// File: rtl/video_frame_monitor_crc16_step.sv
// Combinational parallel CRC-16 update absorbing W data bits in one step.
module crc16_step
  import video_mon_pkg::*;
#(
  parameter int W = 9
) (
  input  logic [15:0]  crc_in,
  input  logic [W-1:0] data,
  output logic [15:0]  crc_out
);
  logic [15:0] data16;

  assign data16  = 16'(data);
  assign crc_out = crc16_next(crc_in, data16, W);
endmodule

// File: rtl/video_frame_monitor.sv
// Raster monitor: line/frame timing, per-frame CRC-16 signature and stability flags.
// Optional CRC_COMPARE_EN adds expected_crc_i / sticky crc_mismatch_o.
module video_frame_monitor
  import video_mon_pkg::*;
#(
  parameter int RGB_W    = 9,
  parameter int HCNT_W   = 10,
  parameter int VCNT_W   = 10,
  parameter int SYNC_POL = 0
) (
  input  logic              clk_12mhz,
  input  logic              reset_n,
  input  logic              pix_ce_i,
  input  logic [RGB_W-1:0]  rgb_i,
  input  logic              hsync_i,
  input  logic              vsync_i,
  input  logic              hblank_i,
  input  logic              vblank_i,
  output logic [HCNT_W-1:0] h_total_o,
  output logic [HCNT_W-1:0] h_active_o,
  output logic [VCNT_W-1:0] v_active_o,
  output logic [15:0]       frame_crc_o,
  output logic [15:0]       frame_cnt_o,
  output logic              frame_done_o,
  output logic              stable_o,
  output logic              timing_err_o
`ifdef CRC_COMPARE_EN
  ,
  input  logic [15:0]       expected_crc_i,
  output logic              crc_mismatch_o
`endif
);
  logic [0:0]        state;
  logic              hs_q, vs_q, hs_lvl, vs_lvl, hedge, vedge, active, close;
  logic              line_act, have_prev, same;
  logic [HCNT_W-1:0] pix_cnt, act_cnt, h_total_q, h_act_q, pix_inc, act_inc, ht_n, ha_n;
  logic [VCNT_W-1:0] line_cnt, line_inc, lc_n;
  logic [15:0]       crc_q, crc_seed, crc_step, crc_d;

  assign hs_lvl = (SYNC_POL != 0) ? hsync_i : ~hsync_i;
  assign vs_lvl = (SYNC_POL != 0) ? vsync_i : ~vsync_i;
  assign hedge  = hs_lvl & ~hs_q;
  assign vedge  = vs_lvl & ~vs_q;
  assign active = ~hblank_i & ~vblank_i;
  assign close  = pix_ce_i & vedge & (state == S_FRAME);

  assign pix_inc  = (&pix_cnt) ? pix_cnt : pix_cnt + HCNT_W'(1);
  assign act_inc  = (active && !(&act_cnt)) ? act_cnt + HCNT_W'(1) : act_cnt;
  assign line_inc = (&line_cnt) ? line_cnt : line_cnt + VCNT_W'(1);

  // Frame close sees the line closed on the same sample.
  assign ht_n = hedge ? pix_inc : h_total_q;
  assign ha_n = (hedge && line_act) ? act_cnt : h_act_q;
  assign lc_n = (hedge && line_act) ? line_inc : line_cnt;
  assign same = (ht_n == h_total_o) && (ha_n == h_active_o) && (lc_n == v_active_o);

  // Edge pixel is hashed into the new frame.
  assign crc_seed = vedge ? CRC_INIT : crc_q;
  assign crc_d    = active ? crc_step : crc_seed;

  crc16_step #(.W(RGB_W)) u_crc (
    .crc_in  (crc_seed),
    .data    (rgb_i),
    .crc_out (crc_step)
  );

  always_ff @(posedge clk_12mhz or negedge reset_n) begin
    if (!reset_n) begin
      state        <= S_WAIT;
      hs_q         <= 1'b0;
      vs_q         <= 1'b0;
      pix_cnt      <= '0;
      act_cnt      <= '0;
      line_cnt     <= '0;
      line_act     <= 1'b0;
      h_total_q    <= '0;
      h_act_q      <= '0;
      crc_q        <= CRC_INIT;
      have_prev    <= 1'b0;
      h_total_o    <= '0;
      h_active_o   <= '0;
      v_active_o   <= '0;
      frame_crc_o  <= '0;
      frame_cnt_o  <= '0;
      frame_done_o <= 1'b0;
      stable_o     <= 1'b0;
      timing_err_o <= 1'b0;
    end else begin
      frame_done_o <= close;
      if (pix_ce_i && (state == S_FRAME || vedge)) crc_q <= crc_d;
      if (pix_ce_i) begin
        hs_q <= hs_lvl;
        vs_q <= vs_lvl;
        if (state == S_WAIT) begin
          if (vedge) begin
            state    <= S_FRAME;
            pix_cnt  <= '0;
            act_cnt  <= HCNT_W'(active);
            line_act <= active;
            line_cnt <= '0;
          end
        end else begin
          if (hedge) begin
            h_total_q <= pix_inc;
            pix_cnt   <= '0;
            act_cnt   <= HCNT_W'(active);
            line_act  <= active;
            if (line_act) begin
              h_act_q  <= act_cnt;
              line_cnt <= line_inc;
            end
          end else begin
            pix_cnt  <= pix_inc;
            act_cnt  <= act_inc;
            line_act <= line_act | active;
          end
          if (vedge) begin
            h_total_o    <= ht_n;
            h_active_o   <= ha_n;
            v_active_o   <= lc_n;
            frame_crc_o  <= crc_q;
            frame_cnt_o  <= frame_cnt_o + 16'd1;
            stable_o     <= have_prev & same;
            timing_err_o <= timing_err_o | (stable_o & ~same);
            have_prev    <= 1'b1;
            line_cnt     <= '0;
          end
        end
      end
    end
  end

`ifdef CRC_COMPARE_EN
  always_ff @(posedge clk_12mhz or negedge reset_n) begin
    if (!reset_n)                            crc_mismatch_o <= 1'b0;
    else if (close && crc_q != expected_crc_i) crc_mismatch_o <= 1'b1;
  end
`endif
endmodule
